// File: rtl/program_feeder_if.sv
// Run/Done feeder bus: program load port, start control, processor handshake and status.
// Error is present only when FEEDER_TIMEOUT_EN is defined.
interface program_feeder_if #(
  parameter int ADDR_W = 5
);
  logic              Prog_we;
  logic [ADDR_W-1:0] Prog_addr;
  logic [15:0]       Prog_data;
  logic              Start;
  logic              Done;
  logic [15:0]       DIN;
  logic              Run;
  logic              Busy;
  logic              Finished;
  logic [ADDR_W-1:0] PC;
  logic [15:0]       Instr_count;
`ifdef FEEDER_TIMEOUT_EN
  logic              Error;

  modport master (
    input  Prog_we, Prog_addr, Prog_data, Start, Done,
    output DIN, Run, Busy, Finished, PC, Instr_count, Error
  );
  modport slave (
    output Prog_we, Prog_addr, Prog_data, Start, Done,
    input  DIN, Run, Busy, Finished, PC, Instr_count, Error
  );
`else
  modport master (
    input  Prog_we, Prog_addr, Prog_data, Start, Done,
    output DIN, Run, Busy, Finished, PC, Instr_count
  );
  modport slave (
    output Prog_we, Prog_addr, Prog_data, Start, Done,
    input  DIN, Run, Busy, Finished, PC, Instr_count
  );
`endif
endinterface

// File: rtl/program_feeder.sv
// Program RAM plus Run/Done initiator that streams instructions (and mvi immediates) to the processor.
// Optional WAIT watchdog with sticky Error output: define FEEDER_TIMEOUT_EN.
module program_feeder #(
  parameter int         ADDR_W  = 5,
  parameter int         OPC_LSB = 13,
  parameter logic [2:0] MVI_OP  = 3'b001,
  parameter logic [2:0] HALT_OP = 3'b111,
  parameter int         TMO_CYC = 64
) (
  input logic               Clock,
  input logic               Reset,
  program_feeder_if.master  bus
);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_IMM, S_WAIT, S_END} state_t;

  state_t            state, state_nx;
  logic [15:0]       mem [2**ADDR_W];
  logic [ADDR_W-1:0] pc, pc_inc1;
  logic [ADDR_W:0]   pc_sum;
  logic [15:0]       cur_word, imm_word, din_q, instr_cnt;
  logic [2:0]        op;
  logic              busy, start_ok, issuing, tmo_hit;

  // RAM is frozen while busy, so the opcode at PC stays valid through WAIT
  always_comb begin
    cur_word = mem[pc];
    pc_inc1  = pc + ADDR_W'(1);
    imm_word = mem[pc_inc1];
    op       = cur_word[OPC_LSB+2:OPC_LSB];
    pc_sum   = {1'b0, pc} + ((op == MVI_OP) ? (ADDR_W+1)'(2) : (ADDR_W+1)'(1));
    busy     = (state == S_ISSUE) || (state == S_IMM) || (state == S_WAIT);
    start_ok = bus.Start && !bus.Prog_we && !busy;
    issuing  = (state == S_ISSUE) && (op != HALT_OP);
  end

  always_ff @(posedge Clock) begin
    if (bus.Prog_we && !busy) mem[bus.Prog_addr] <= bus.Prog_data;
  end

`ifdef FEEDER_TIMEOUT_EN
  localparam int TMO_W = $clog2(TMO_CYC + 1);

  logic [TMO_W-1:0] wait_cnt;
  logic             error_q;

  assign tmo_hit = (state == S_WAIT) && !bus.Done && (wait_cnt == TMO_W'(TMO_CYC - 1));

  always_ff @(posedge Clock) begin
    if (Reset || state != S_WAIT || bus.Done) wait_cnt <= '0;
    else                                      wait_cnt <= wait_cnt + TMO_W'(1);
  end

  always_ff @(posedge Clock) begin
    if (Reset)         error_q <= 1'b0;
    else if (start_ok) error_q <= 1'b0;
    else if (tmo_hit)  error_q <= 1'b1;
  end

  always_comb bus.Error = error_q;
`else
  logic unused_tmo;
  assign tmo_hit    = 1'b0;
  assign unused_tmo = (TMO_CYC != 0);
`endif

  always_ff @(posedge Clock) begin
    if (Reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (start_ok) state_nx = S_ISSUE;
      S_ISSUE: begin
        if (op == HALT_OP)     state_nx = S_END;
        else if (op == MVI_OP) state_nx = S_IMM;
        else                   state_nx = S_WAIT;
      end
      S_IMM:   state_nx = S_WAIT;
      S_WAIT: begin
        if (bus.Done)    state_nx = pc_sum[ADDR_W] ? S_END : S_ISSUE;
        else if (tmo_hit) state_nx = S_END;
      end
      S_END:   state_nx = start_ok ? S_ISSUE : S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      pc        <= '0;
      instr_cnt <= '0;
      din_q     <= '0;
    end else begin
      unique case (state)
        S_IDLE, S_END: if (start_ok) begin
          pc        <= '0;
          instr_cnt <= '0;
        end
        S_ISSUE: if (issuing) din_q <= cur_word;
        S_IMM:   din_q <= imm_word;
        S_WAIT:  if (bus.Done) begin
          pc <= pc_sum[ADDR_W-1:0];
          if (instr_cnt != '1) instr_cnt <= instr_cnt + 16'd1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.Run         = issuing;
    bus.DIN         = issuing ? cur_word : (state == S_IMM) ? imm_word : din_q;
    bus.Busy        = busy;
    bus.Finished    = (state == S_END);
    bus.PC          = pc;
    bus.Instr_count = instr_cnt;
  end

endmodule
